// File: rtl/effect_change_sequencer.sv
// Debounces the DIP-switch effect word and sequences pop-free effect changes:
// ramp gain to mute, swap effect_sel, settle, then ramp gain back to unity.
module effect_change_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned GAIN_W          = 16,
  parameter int unsigned RAMP_STEP       = 1024,
  parameter int unsigned SETTLE_SAMPLES  = 32
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [3:0]        ds_in,
  input  logic              sample_tick,
  output logic [3:0]        effect_sel,
  output logic [GAIN_W-1:0] gain,
  output logic              busy,
  output logic              sel_changed
);

  localparam int unsigned SEL_W = 4;
  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned ST_W  = $clog2(SETTLE_SAMPLES + 1);

  localparam logic [GAIN_W-1:0] GMAX    = '1;
  localparam logic [GAIN_W-1:0] STEP    = GAIN_W'(RAMP_STEP);
  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0]   ST_LAST = ST_W'(SETTLE_SAMPLES - 1);
  localparam logic [ST_W-1:0]   ST_DONE = ST_W'(SETTLE_SAMPLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_DOWN = 2'd1,
    SETTLE    = 2'd2,
    RAMP_UP   = 2'd3
  } state_t;

  logic [SEL_W-1:0]  candidate_q;
  logic [SEL_W-1:0]  stable_q;
  logic [DB_W-1:0]   db_cnt_q;

  state_t            state_q, state_d;
  logic [GAIN_W-1:0] gain_d;
  logic [SEL_W-1:0]  sel_d;
  logic [ST_W-1:0]   settle_q, settle_d;
  logic              sel_changed_d;
  logic              busy_d;
  logic [GAIN_W-1:0] gain_dn_c;
  logic [GAIN_W-1:0] gain_up_c;

  // Debounce: any change of ds_in restarts the stability count.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      candidate_q <= '0;
      stable_q    <= '0;
      db_cnt_q    <= '0;
    end else if (ds_in != candidate_q) begin
      candidate_q <= ds_in;
      db_cnt_q    <= '0;
    end else if (db_cnt_q == DB_LAST) begin
      stable_q    <= candidate_q;
    end else begin
      db_cnt_q    <= db_cnt_q + DB_W'(1);
    end
  end

  // Saturating ramp steps; never wrap past mute or unity.
  always_comb begin
    gain_dn_c = (gain <= STEP) ? '0 : gain - STEP;
    gain_up_c = ((GMAX - gain) <= STEP) ? GMAX : gain + STEP;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= RAMP_UP;
      gain        <= '0;
      effect_sel  <= '0;
      settle_q    <= '0;
      sel_changed <= 1'b0;
      busy        <= 1'b1;
    end else begin
      state_q     <= state_d;
      gain        <= gain_d;
      effect_sel  <= sel_d;
      settle_q    <= settle_d;
      sel_changed <= sel_changed_d;
      busy        <= busy_d;
    end
  end

  // A switch mismatch reverses a ramp before any tick in the same cycle is used.
  always_comb begin
    state_d       = state_q;
    gain_d        = gain;
    sel_d         = effect_sel;
    settle_d      = settle_q;
    sel_changed_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (stable_q != effect_sel) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (stable_q == effect_sel) begin
          state_d = RAMP_UP;
        end else if (sample_tick) begin
          gain_d = gain_dn_c;
          if (gain_dn_c == '0) begin
            sel_d         = stable_q;
            sel_changed_d = 1'b1;
            settle_d      = '0;
            state_d       = SETTLE;
          end
        end
      end
      SETTLE: begin
        gain_d = '0;
        if (sample_tick) begin
          if (settle_q == ST_LAST) begin
            settle_d = ST_DONE;
            state_d  = RAMP_UP;
          end else begin
            settle_d = settle_q + ST_W'(1);
          end
        end
      end
      RAMP_UP: begin
        if (stable_q != effect_sel) begin
          state_d = RAMP_DOWN;
        end else if (sample_tick) begin
          gain_d = gain_up_c;
          if (gain_up_c == GMAX) state_d = IDLE;
        end
      end
      default: state_d = RAMP_UP;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: doc/effect_change_sequencer.md
Name: effect_change_sequencer

Overview:
- Takes the 4-bit synchronized DIP-switch word, debounces it, and sequences pop-free effect changes for the audio datapath.
- On a debounced change it ramps output gain down, swaps the effect select, waits a settle interval, then ramps gain back up.
- Sits between the switch synchronizer and the effect mux/gain multiplier.
- Ramps and settle timing advance on the audio sample strobe.

Parameters:
- DEBOUNCE_CYCLES, 1000000: sys_clk cycles the input must be stable before it is accepted (>=2).
- GAIN_W, 16: gain output width; full scale GMAX = 2^GAIN_W-1.
- RAMP_STEP, 1024: gain increment/decrement per sample_tick (1..GMAX).
- SETTLE_SAMPLES, 32: sample_ticks held at zero gain after the swap (>=1).

Ports:
- sys_clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- ds_in  in  4  synchronized switch word; already metastability-safe.
- sample_tick  in  1  one-cycle pulse per audio sample.
- effect_sel  out  4  effect selection applied to the datapath.
- gain  out  GAIN_W  unsigned output gain, 0 = mute, GMAX = unity.
- busy  out  1  high whenever state != IDLE.
- sel_changed  out  1  one-cycle pulse in the cycle effect_sel is updated.

Behaviour:
- Reset values, applied on sys_clk edge with reset=1:
  - effect_sel=0, gain=0, sel_changed=0.
  - Debounced word stable=0, candidate=0, debounce count=0.
  - Settle count=0, state=RAMP_UP, so busy=1 (soft start).
- Reset mid-ramp aborts the sequence immediately; no partial state is retained.
- Debounce:
  - If ds_in != candidate: candidate<=ds_in, count<=0.
  - Else if count==DEBOUNCE_CYCLES-1: stable<=candidate, and count holds.
  - Else count++.
  - stable therefore updates DEBOUNCE_CYCLES cycles after ds_in last changed; any glitch restarts the count.
- Ramp arithmetic is saturating and has no wrap:
  - Down: gain<=(gain<=RAMP_STEP)?0:gain-RAMP_STEP.
  - Up: gain<=(GMAX-gain<=RAMP_STEP)?GMAX:gain+RAMP_STEP.
  - gain changes only in cycles where sample_tick=1.
- IDLE: gain==GMAX. If stable!=effect_sel, go to RAMP_DOWN next cycle (no tick required).
- RAMP_DOWN:
  - If stable==effect_sel (switch reverted), go to RAMP_UP from the current gain; this check has priority over a tick in the same cycle.
  - Else, on a tick, decrement. If the decrement reaches 0:
    - effect_sel<=stable (the value at that cycle) and sel_changed=1.
    - settle count<=0, state<=SETTLE.
- SETTLE:
  - gain held at 0.
  - Each tick increments the settle count.
  - On the tick where the count reaches SETTLE_SAMPLES, go to RAMP_UP. The first increment occurs on the following tick.
  - stable changes in SETTLE are ignored here and handled from RAMP_UP.
- RAMP_UP:
  - If stable!=effect_sel, go to RAMP_DOWN from the current gain; this check has priority over a tick.
  - Else, on a tick, increment. Reaching GMAX goes to IDLE.
- Soft start after reset: stable==effect_sel==0, so the block ramps 0→GMAX, then sits in IDLE.
- sample_tick is never required to be periodic; with no ticks, gain freezes and the state holds, except for the mismatch-driven transitions above.
- Ramp length from full scale = ceil(GMAX/RAMP_STEP) ticks; 64 with the defaults.
- Outputs are registered; latency from stable change to leaving IDLE is 1 cycle.

Test Plan (DEBOUNCE_CYCLES=8, GAIN_W=16, RAMP_STEP=16384, SETTLE_SAMPLES=4, tick every 4 cycles):
- Reset released, ds_in=0 → gain steps 0,16384,32768,49152,65535 over 4 ticks; then busy=0, effect_sel=0, sel_changed never pulses.
- From IDLE, ds_in=4'h5 held → stable=5 after 8 cycles. gain ramps 65535→49151→32767→16383→0 in 4 ticks. sel_changed pulses once, with effect_sel=5 in the same cycle gain hits 0. gain=0 holds for 4 ticks, ramps up over 4 ticks, then busy=0.
- ds_in toggles 0→5→0 with a 5-cycle glitch → stable never changes; busy stays 0 and gain stays 65535.
- During RAMP_DOWN with gain=32767, ds_in returns to the original value and is debounced → state RAMP_UP, gain 49151 on the next tick; effect_sel unchanged, no sel_changed.
- During SETTLE after a swap to 5, ds_in=4'hA is debounced → completes ramp up to 65535? No: at RAMP_UP entry the mismatch is seen and the block goes straight to RAMP_DOWN at gain 0. It then swaps to A with a second sel_changed, settles 4 ticks, and ramps up.
- Assert reset while in RAMP_DOWN at gain=32767 → next cycle gain=0, effect_sel=0, state RAMP_UP, busy=1.
